// File: rtl/multicycle_control_unit_if.sv
// Handshake/control bundle between the IR/datapath side and the multicycle control unit.
// Optional macro ILLEGAL_OP_TRAP_EN adds the sticky illegal-opcode output.
interface multicycle_control_unit_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 32
);
  logic [WORD_W-1:0] instr;
  logic              ihit;
  logic              dhit;
  logic              iREN;
  logic              dREN;
  logic              dWEN;
  logic              IRWrite;
  logic              PCWrite;
  logic              PCWriteCond;
  logic              BNE;
  logic [1:0]        JumpSel;
  logic              RegWr;
  logic [1:0]        RegDst;
  logic [1:0]        MemToReg;
  logic [1:0]        ALUsrc;
  logic              ExtOp;
  logic [3:0]        alu_op;
  logic              halt;
  logic              timeout;
  logic [CNT_W-1:0]  retired;
`ifdef ILLEGAL_OP_TRAP_EN
  logic              illegal;

  modport master (
    input  instr, ihit, dhit,
    output iREN, dREN, dWEN, IRWrite, PCWrite, PCWriteCond, BNE, JumpSel,
           RegWr, RegDst, MemToReg, ALUsrc, ExtOp, alu_op, halt, timeout, retired, illegal
  );
  modport slave (
    output instr, ihit, dhit,
    input  iREN, dREN, dWEN, IRWrite, PCWrite, PCWriteCond, BNE, JumpSel,
           RegWr, RegDst, MemToReg, ALUsrc, ExtOp, alu_op, halt, timeout, retired, illegal
  );
`else
  modport master (
    input  instr, ihit, dhit,
    output iREN, dREN, dWEN, IRWrite, PCWrite, PCWriteCond, BNE, JumpSel,
           RegWr, RegDst, MemToReg, ALUsrc, ExtOp, alu_op, halt, timeout, retired
  );
  modport slave (
    output instr, ihit, dhit,
    input  iREN, dREN, dWEN, IRWrite, PCWrite, PCWriteCond, BNE, JumpSel,
           RegWr, RegDst, MemToReg, ALUsrc, ExtOp, alu_op, halt, timeout, retired
  );
`endif
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/HALTED) with wait-state watchdog and
// saturating retired-instruction counter. Optional macro: ILLEGAL_OP_TRAP_EN (trap unknown ops).
module multicycle_control_unit #(
  parameter int WORD_W      = 32,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 32
) (
  input logic                       CLK,
  input logic                       nRST,
  multicycle_control_unit_if.master bus
);

  localparam int WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
                         ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                         OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20,
                         F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
                         F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
  } state_t;

  state_t           r_state;
  logic [WD_W-1:0]  r_wait;
  logic             r_timeout;
  logic [CNT_W-1:0] r_retired;
`ifdef ILLEGAL_OP_TRAP_EN
  logic             r_illegal;
`endif

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_unused;
  logic       w_known, w_rtype, w_jr, w_br, w_j, w_jal, w_lw, w_sw, w_halt_op, w_wb;
  logic [3:0] w_alu_op;
  logic [1:0] w_alusrc;
  logic       w_extop;
  logic [1:0] w_regdst;
  logic       w_waiting, w_trip, w_retire;

  assign w_op     = bus.instr[WORD_W-1 -: 6];
  assign w_funct  = bus.instr[5:0];
  assign w_unused = ^bus.instr[WORD_W-7:6];

  always_comb begin
    w_known   = 1'b0;
    w_rtype   = 1'b0;
    w_jr      = 1'b0;
    w_br      = 1'b0;
    w_j       = 1'b0;
    w_jal     = 1'b0;
    w_lw      = 1'b0;
    w_sw      = 1'b0;
    w_halt_op = 1'b0;
    w_wb      = 1'b0;
    w_alu_op  = ALU_SLL;
    w_alusrc  = 2'b00;
    w_extop   = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_known  = 1'b1;
        w_rtype  = 1'b1;
        w_wb     = 1'b1;
        w_alusrc = 2'b01;
        case (w_funct)
          F_SLL:          begin w_alu_op = ALU_SLL; w_alusrc = 2'b10; end
          F_SRL:          begin w_alu_op = ALU_SRL; w_alusrc = 2'b10; end
          F_JR:           begin w_jr = 1'b1; w_wb = 1'b0; w_alusrc = 2'b00; end
          F_ADD, F_ADDU:  w_alu_op = ALU_ADD;
          F_SUB, F_SUBU:  w_alu_op = ALU_SUB;
          F_AND:          w_alu_op = ALU_AND;
          F_OR:           w_alu_op = ALU_OR;
          F_XOR:          w_alu_op = ALU_XOR;
          F_NOR:          w_alu_op = ALU_NOR;
          F_SLT:          w_alu_op = ALU_SLT;
          F_SLTU:         w_alu_op = ALU_SLTU;
          default: begin
            w_known  = 1'b0;
            w_rtype  = 1'b0;
            w_wb     = 1'b0;
            w_alusrc = 2'b00;
          end
        endcase
      end
      OP_J:              begin w_known = 1'b1; w_j = 1'b1; end
      OP_JAL:            begin w_known = 1'b1; w_jal = 1'b1; w_wb = 1'b1; end
      OP_BEQ, OP_BNE:    begin w_known = 1'b1; w_br = 1'b1; w_alu_op = ALU_SUB; w_alusrc = 2'b01; end
      OP_ADDI, OP_ADDIU: begin w_known = 1'b1; w_wb = 1'b1; w_alu_op = ALU_ADD; w_extop = 1'b1; end
      OP_SLTI:           begin w_known = 1'b1; w_wb = 1'b1; w_alu_op = ALU_SLT; w_extop = 1'b1; end
      OP_SLTIU:          begin w_known = 1'b1; w_wb = 1'b1; w_alu_op = ALU_SLTU; w_extop = 1'b1; end
      OP_ANDI:           begin w_known = 1'b1; w_wb = 1'b1; w_alu_op = ALU_AND; end
      OP_ORI:            begin w_known = 1'b1; w_wb = 1'b1; w_alu_op = ALU_OR; end
      OP_XORI:           begin w_known = 1'b1; w_wb = 1'b1; w_alu_op = ALU_XOR; end
      OP_LUI:            begin w_known = 1'b1; w_wb = 1'b1; end
      OP_LW:             begin w_known = 1'b1; w_lw = 1'b1; w_alu_op = ALU_ADD; w_extop = 1'b1; end
      OP_SW:             begin w_known = 1'b1; w_sw = 1'b1; w_alu_op = ALU_ADD; w_extop = 1'b1; end
      OP_HALT:           begin w_known = 1'b1; w_halt_op = 1'b1; end
      default: ;
    endcase
  end

  assign w_regdst = w_jal ? 2'b10 : ((w_rtype && w_wb) ? 2'b01 : 2'b00);

  // A hit in the final allowed cycle wins over the watchdog.
  assign w_waiting = ((r_state == S_FETCH) && !bus.ihit) || ((r_state == S_MEM) && !bus.dhit);
  assign w_trip    = (TIMEOUT_CYC > 0) && w_waiting && (r_wait == WD_LAST);
  assign w_retire  = ((r_state == S_EXEC) && !w_lw && !w_sw && !w_wb) ||
                     ((r_state == S_MEM) && bus.dhit && !w_lw) ||
                     (r_state == S_WB);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_timeout <= 1'b0;
      r_retired <= '0;
`ifdef ILLEGAL_OP_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      r_wait <= (w_waiting && !w_trip && (TIMEOUT_CYC > 0)) ? r_wait + 1'b1 : '0;
      if (w_retire && (r_retired != '1))
        r_retired <= r_retired + 1'b1;
      if (w_trip) begin
        r_state   <= S_HALTED;
        r_timeout <= 1'b1;
      end else begin
        case (r_state)
          S_FETCH:  if (bus.ihit) r_state <= S_DECODE;
          S_DECODE: begin
            if (w_halt_op)
              r_state <= S_HALTED;
`ifdef ILLEGAL_OP_TRAP_EN
            else if (!w_known) begin
              r_state   <= S_HALTED;
              r_illegal <= 1'b1;
            end
`endif
            else
              r_state <= S_EXEC;
          end
          S_EXEC: begin
            if (w_lw || w_sw)
              r_state <= S_MEM;
            else if (w_wb)
              r_state <= S_WB;
            else
              r_state <= S_FETCH;
          end
          S_MEM:    if (bus.dhit) r_state <= w_lw ? S_WB : S_FETCH;
          S_WB:     r_state <= S_FETCH;
          default:  r_state <= S_HALTED;
        endcase
      end
    end
  end

  // Enables are gated by nRST so a reset pulse kills them without waiting for an edge.
  always_comb begin
    bus.iREN        = 1'b0;
    bus.dREN        = 1'b0;
    bus.dWEN        = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.BNE         = 1'b0;
    bus.JumpSel     = 2'b00;
    bus.RegWr       = 1'b0;
    bus.RegDst      = 2'b00;
    bus.MemToReg    = 2'b00;
    bus.ALUsrc      = 2'b00;
    bus.ExtOp       = 1'b0;
    bus.alu_op      = ALU_SLL;
    if (nRST) begin
      case (r_state)
        S_FETCH: begin
          bus.iREN    = 1'b1;
          bus.IRWrite = bus.ihit;
          bus.PCWrite = bus.ihit;
        end
        S_EXEC: begin
          bus.alu_op      = w_alu_op;
          bus.ALUsrc      = w_alusrc;
          bus.ExtOp       = w_extop;
          bus.RegDst      = w_regdst;
          bus.PCWriteCond = w_br;
          bus.BNE         = w_br && (w_op == OP_BNE);
          bus.PCWrite     = w_j || w_jr;
          bus.JumpSel     = w_j ? 2'b10 : (w_jr ? 2'b01 : 2'b00);
        end
        S_MEM: begin
          bus.alu_op = w_alu_op;
          bus.ALUsrc = w_alusrc;
          bus.ExtOp  = w_extop;
          bus.dREN   = w_lw;
          bus.dWEN   = w_sw;
        end
        S_WB: begin
          bus.alu_op   = w_alu_op;
          bus.ALUsrc   = w_alusrc;
          bus.ExtOp    = w_extop;
          bus.RegWr    = 1'b1;
          bus.RegDst   = w_regdst;
          bus.MemToReg = w_lw ? 2'b01 : (w_jal ? 2'b10 : 2'b00);
          bus.PCWrite  = w_jal;
          bus.JumpSel  = w_jal ? 2'b10 : 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign bus.halt    = nRST && (r_state == S_HALTED);
  assign bus.timeout = r_timeout;
  assign bus.retired = r_retired;
`ifdef ILLEGAL_OP_TRAP_EN
  assign bus.illegal = r_illegal;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: each instruction is expanded into its expected
// per-cycle control trace from its class and wait counts, and compared cycle by cycle.
module tb_multicycle_control_unit;
  localparam int TO = 4;

  localparam int C_RALU = 0, C_SHIFT = 1, C_JR = 2, C_IMM = 3, C_LUI = 4, C_BR = 5, C_J = 6,
                 C_JAL = 7, C_LW = 8, C_SW = 9, C_HALT = 10, C_NOP = 11;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  multicycle_control_unit_if #(.WORD_W(32), .CNT_W(32)) bus ();

  multicycle_control_unit #(.WORD_W(32), .TIMEOUT_CYC(TO), .CNT_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int exp_retired = 0;
  bit exp_timeout = 1'b0;
  bit exp_illegal = 1'b0;

  int functs[14] = '{'h00, 'h02, 'h08, 'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B, 'h3F};
  int opcodes[16] = '{'h02, 'h03, 'h04, 'h05, 'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F,
                      'h23, 'h2B, 'h3E, 'h3F};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] mk(input logic ire, input logic dre, input logic dwe,
                                     input logic irw, input logic pcw, input logic pcc,
                                     input logic bne, input logic [1:0] js, input logic rw,
                                     input logic [1:0] m2r, input logic h, input logic t);
    return {ire, dre, dwe, irw, pcw, pcc, bne, js, rw, m2r, h, t};
  endfunction

  function automatic logic [13:0] ctl_now();
    return {bus.iREN, bus.dREN, bus.dWEN, bus.IRWrite, bus.PCWrite, bus.PCWriteCond, bus.BNE,
            bus.JumpSel, bus.RegWr, bus.MemToReg, bus.halt, bus.timeout};
  endfunction

  // Returns the instruction class and the expected EXEC {alu_op, ALUsrc, ExtOp}.
  function automatic int classify(input logic [31:0] ins, output logic [6:0] alu);
    logic [5:0] op;
    logic [5:0] fn;
    int cls;
    op = ins[31:26];
    fn = ins[5:0];
    alu = '0;
    cls = C_NOP;
    case (op)
      6'h00: case (fn)
        6'h00: begin cls = C_SHIFT; alu = {4'd0, 2'b10, 1'b0}; end
        6'h02: begin cls = C_SHIFT; alu = {4'd1, 2'b10, 1'b0}; end
        6'h08: cls = C_JR;
        6'h20, 6'h21: begin cls = C_RALU; alu = {4'd2, 2'b01, 1'b0}; end
        6'h22, 6'h23: begin cls = C_RALU; alu = {4'd3, 2'b01, 1'b0}; end
        6'h24: begin cls = C_RALU; alu = {4'd4, 2'b01, 1'b0}; end
        6'h25: begin cls = C_RALU; alu = {4'd5, 2'b01, 1'b0}; end
        6'h26: begin cls = C_RALU; alu = {4'd6, 2'b01, 1'b0}; end
        6'h27: begin cls = C_RALU; alu = {4'd7, 2'b01, 1'b0}; end
        6'h2A: begin cls = C_RALU; alu = {4'd8, 2'b01, 1'b0}; end
        6'h2B: begin cls = C_RALU; alu = {4'd9, 2'b01, 1'b0}; end
        default: cls = C_NOP;
      endcase
      6'h02: cls = C_J;
      6'h03: cls = C_JAL;
      6'h04, 6'h05: begin cls = C_BR; alu = {4'd3, 2'b01, 1'b0}; end
      6'h08, 6'h09: begin cls = C_IMM; alu = {4'd2, 2'b00, 1'b1}; end
      6'h0A: begin cls = C_IMM; alu = {4'd8, 2'b00, 1'b1}; end
      6'h0B: begin cls = C_IMM; alu = {4'd9, 2'b00, 1'b1}; end
      6'h0C: begin cls = C_IMM; alu = {4'd4, 2'b00, 1'b0}; end
      6'h0D: begin cls = C_IMM; alu = {4'd5, 2'b00, 1'b0}; end
      6'h0E: begin cls = C_IMM; alu = {4'd6, 2'b00, 1'b0}; end
      6'h0F: cls = C_LUI;
      6'h23: begin cls = C_LW; alu = {4'd2, 2'b00, 1'b1}; end
      6'h2B: begin cls = C_SW; alu = {4'd2, 2'b00, 1'b1}; end
      6'h3F: cls = C_HALT;
      default: cls = C_NOP;
    endcase
    return cls;
  endfunction

  task automatic step(input logic ih, input logic dh, input logic [13:0] exp, input string tag);
    bus.ihit = ih;
    bus.dhit = dh;
    #1;
    check_eq(tag, 32'(ctl_now()), 32'(exp));
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    bus.ihit = 1'b0;
    bus.dhit = 1'b0;
    #1;
    check_eq("rst_ctl", 32'(ctl_now()), 32'd0);
    check_eq("rst_retired", bus.retired, 32'd0);
`ifdef ILLEGAL_OP_TRAP_EN
    check_eq("rst_illegal", 32'(bus.illegal), 32'd0);
`endif
    @(posedge CLK);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    exp_retired = 0;
    exp_timeout = 1'b0;
    exp_illegal = 1'b0;
  endtask

  task automatic halted_and_reset();
    for (int k = 0; k < 2; k++)
      step(1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, exp_timeout), "halted");
`ifdef ILLEGAL_OP_TRAP_EN
    check_eq("illegal", 32'(bus.illegal), 32'(exp_illegal));
`endif
    check_eq("retired_halted", bus.retired, 32'(exp_retired));
    do_reset();
  endtask

  task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input int abort_at);
    int cls;
    logic [6:0] alu;
    logic [13:0] exp;
    logic dre, dwe;
    cls = classify(ins, alu);
    bus.instr = ins;
    $display("txn instr=%08h class=%0d iwait=%0d dwait=%0d retired_before=%0d", ins, cls, iw, dw, exp_retired);
    if (iw >= TO) begin
      for (int k = 0; k < TO; k++)
        step(1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0), "fetch_wait");
      exp_timeout = 1'b1;
      halted_and_reset();
      return;
    end
    for (int k = 0; k < iw; k++)
      step(1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0), "fetch_wait");
    step(1'b1, 1'b0, mk(1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0), "fetch_hit");
    step(1'b0, 1'b0, 14'd0, "decode");
    if (cls == C_HALT) begin
      halted_and_reset();
      return;
    end
`ifdef ILLEGAL_OP_TRAP_EN
    if (cls == C_NOP) begin
      exp_illegal = 1'b1;
      halted_and_reset();
      return;
    end
`endif
    bus.ihit = 1'b0;
    bus.dhit = 1'b0;
    #1;
    case (cls)
      C_BR:    exp = mk(0, 0, 0, 0, 0, 1, ins[26], 2'b00, 0, 2'b00, 0, 0);
      C_J:     exp = mk(0, 0, 0, 0, 1, 0, 0, 2'b10, 0, 2'b00, 0, 0);
      C_JR:    exp = mk(0, 0, 0, 0, 1, 0, 0, 2'b01, 0, 2'b00, 0, 0);
      default: exp = 14'd0;
    endcase
    check_eq("exec", 32'(ctl_now()), 32'(exp));
    if (cls == C_RALU || cls == C_SHIFT || cls == C_IMM || cls == C_BR || cls == C_LW || cls == C_SW) begin
      check_eq("exec_aluop", 32'(bus.alu_op), 32'(alu[6:3]));
      check_eq("exec_alusrc", 32'(bus.ALUsrc), 32'(alu[2:1]));
      if (cls != C_BR)
        check_eq("exec_extop", 32'(bus.ExtOp), 32'(alu[0]));
    end
    @(posedge CLK);
    #1;
    if (cls == C_LW || cls == C_SW) begin
      dre = (cls == C_LW);
      dwe = (cls == C_SW);
      exp = mk(0, dre, dwe, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
      for (int k = 0; k < ((dw >= TO) ? TO : dw); k++) begin
        if (k == abort_at) begin
          bus.dhit = 1'b0;
          #1;
          check_eq("abort_pre_dwen", 32'(bus.dWEN), 32'(dwe));
          #2;
          nRST = 1'b0;
          #1;
          check_eq("abort_ctl", 32'(ctl_now()), 32'd0);
          check_eq("abort_retired", bus.retired, 32'd0);
          @(posedge CLK);
          #1;
          nRST = 1'b1;
          exp_retired = 0;
          exp_timeout = 1'b0;
          return;
        end
        step(1'b0, 1'b0, exp, "mem_wait");
      end
      if (dw >= TO) begin
        exp_timeout = 1'b1;
        halted_and_reset();
        return;
      end
      step(1'b0, 1'b1, exp, "mem_hit");
    end
    if (cls == C_RALU || cls == C_SHIFT || cls == C_IMM || cls == C_LUI || cls == C_JAL || cls == C_LW) begin
      bus.ihit = 1'b0;
      bus.dhit = 1'b0;
      #1;
      exp = mk(0, 0, 0, 0, (cls == C_JAL), 0, 0, (cls == C_JAL) ? 2'b10 : 2'b00, 1,
               (cls == C_LW) ? 2'b01 : ((cls == C_JAL) ? 2'b10 : 2'b00), 0, 0);
      check_eq("wb", 32'(ctl_now()), 32'(exp));
      check_eq("wb_regdst", 32'(bus.RegDst),
               (cls == C_JAL) ? 32'd2 : ((cls == C_RALU || cls == C_SHIFT) ? 32'd1 : 32'd0));
      @(posedge CLK);
      #1;
    end
    exp_retired++;
    check_eq("retired", bus.retired, 32'(exp_retired));
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 19) == 0) ? int'($urandom_range(TO, TO + 2)) : int'($urandom_range(0, TO - 1));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0] f;
    logic [5:0] o;
    r = $urandom;
    if ($urandom_range(0, 1) == 0) begin
      f = 6'(functs[$urandom_range(0, 13)]);
      return {6'h00, r[25:6], f};
    end
    o = 6'(opcodes[$urandom_range(0, 15)]);
    return {o, r[25:0]};
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    bus.instr = '0;
    bus.ihit  = 1'b0;
    bus.dhit  = 1'b0;
    do_reset();
    run_instr(32'h00221821, 0, 0, -1);   // ADDU
    run_instr(32'h8C220004, 2, 3, -1);   // LW with waits
    run_instr(32'h14220003, 0, 0, -1);   // BNE
    run_instr(32'h14220003, 1, 0, -1);
    run_instr(32'h10220003, 0, 0, -1);   // BEQ
    run_instr(32'hAC220004, 0, 3, 1);    // SW aborted mid-MEM
    run_instr(32'h08000010, 0, 0, -1);   // J
    run_instr(32'h03E00008, 0, 0, -1);   // JR
    run_instr(32'h0C000010, 0, 0, -1);   // JAL
    run_instr(32'h3C011234, 0, 0, -1);   // LUI
    run_instr(32'h3421FFFF, 0, 0, -1);   // ORI
    run_instr(32'hF8000000, 0, 0, -1);   // opcode 0x3E
    run_instr(32'h0000003F, 0, 0, -1);   // unknown funct
    run_instr(32'hAC220004, 0, 0, -1);   // SW
    run_instr(32'h00221821, TO - 1, 0, -1);
    run_instr(32'h8C220004, 0, TO - 1, -1);
    run_instr(32'h00221821, TO, 0, -1);
    run_instr(32'h8C220004, 0, TO, -1);
    run_instr(32'hFC000000, 0, 0, -1);   // HALT
    for (int n = 0; n < 200; n++)
      run_instr(rand_instr(), rand_wait(), rand_wait(), ($urandom_range(0, 29) == 0) ? 0 : -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
